// File: rtl/seg7_pkg.sv
// Shared definitions for the UART-driven 4-digit seven-segment display controller:
// ASCII command bytes, segment pattern table, scan-state enum and byte classifier.
package seg7_pkg;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_HEX,
        CMD_DP,
        CMD_CLEAR,
        CMD_ERR
    } cmd_t;

    typedef struct packed {
        logic       used;
        logic       dp;
        logic [3:0] nib;
    } digit_t;

    typedef struct packed {
        cmd_t       cmd;
        logic [3:0] nib;
    } rx_cmd_t;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_ESC  = 8'h1B;
    localparam logic [7:0] ASCII_DOT  = 8'h2E;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_F_UC = 8'h46;
    localparam logic [7:0] ASCII_X_UC = 8'h58;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_F_LC = 8'h66;
    localparam logic [7:0] ASCII_X_LC = 8'h78;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] DIG_OFF   = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; element 15 (F) is listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic rx_cmd_t classify(input logic [7:0] b);
        rx_cmd_t c;
        c.cmd = CMD_ERR;
        c.nib = '0;
        if (b >= ASCII_0 && b <= ASCII_9) begin
            c.cmd = CMD_HEX;
            c.nib = 4'(b - ASCII_0);
        end else if (b >= ASCII_A_UC && b <= ASCII_F_UC) begin
            c.cmd = CMD_HEX;
            c.nib = 4'(b - ASCII_A_UC + 8'd10);
        end else if (b >= ASCII_A_LC && b <= ASCII_F_LC) begin
            c.cmd = CMD_HEX;
            c.nib = 4'(b - ASCII_A_LC + 8'd10);
        end else if (b == ASCII_DOT) begin
            c.cmd = CMD_DP;
        end else if (b == ASCII_ESC || b == ASCII_X_UC || b == ASCII_X_LC) begin
            c.cmd = CMD_CLEAR;
        end else if (b == ASCII_CR || b == ASCII_LF) begin
            c.cmd = CMD_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment pattern lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_TABLE[i_nibble];
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Four-digit multiplexed seven-segment controller fed by ASCII bytes from a UART;
// all outputs are registered and the scan timing runs independently of rx traffic.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_CYC  = 6750,
    parameter int unsigned BLANK_CYC = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] dig_n,
    output logic       err
);

    localparam int unsigned   MAX_CYC    = (SCAN_CYC > BLANK_CYC) ? SCAN_CYC : BLANK_CYC;
    localparam int unsigned   TW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] SCAN_LAST  = TW'(SCAN_CYC - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);

    digit_t [3:0]  r_buf;
    logic          r_err;
    scan_state_t   r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_idx;
    logic [3:0]    r_dig_n;
    logic [6:0]    r_seg_n;
    logic          r_dp_n;

    rx_cmd_t    w_cmd;
    digit_t     w_cur;
    logic [6:0] w_pattern;

    assign w_cmd = classify(rx_data);
    assign w_cur = r_buf[r_idx];

    seg7_decode u_decode (
        .i_nibble (w_cur.nib),
        .o_seg_n  (w_pattern)
    );

    always_ff @(posedge clk) begin : buf_update
        if (reset) begin
            r_buf <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (rx_valid) begin
                case (w_cmd.cmd)
                    CMD_HEX:   r_buf <= {r_buf[2:0], 1'b1, 1'b0, w_cmd.nib};
                    CMD_DP:    r_buf[0].dp <= 1'b1;
                    CMD_CLEAR: r_buf <= '0;
                    CMD_ERR:   r_err <= 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    // The index advances when ON ends rather than when BLANK ends; BLANK shows nothing,
    // so this is invisible and lets the post-reset BLANK lead straight into index 0.
    always_ff @(posedge clk) begin : scan_fsm
        if (reset) begin
            r_state <= ST_BLANK;
            r_timer <= '0;
            r_idx   <= '0;
            r_dig_n <= DIG_OFF;
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
        end else begin
            case (r_state)
                ST_ON: begin
                    if (r_timer == SCAN_LAST) begin
                        r_state <= ST_BLANK;
                        r_timer <= '0;
                        r_idx   <= r_idx + 2'd1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_BLANK: begin
                    if (r_timer == BLANK_LAST) begin
                        r_state <= ST_ON;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_timer <= '0;
                end
            endcase

            if (r_state == ST_ON) begin
                r_dig_n <= ~(4'b0001 << r_idx);
                r_seg_n <= w_cur.used ? w_pattern : SEG_BLANK;
                r_dp_n  <= ~w_cur.dp;
            end else begin
                r_dig_n <= DIG_OFF;
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= 1'b1;
            end
        end
    end

    assign seg_n = r_seg_n;
    assign dp_n  = r_dp_n;
    assign dig_n = r_dig_n;
    assign err   = r_err;

endmodule

// File: doc/seg7_display_ctrl.md
SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_CYC, default 6750, meaning clk cycles a digit is driven per scan slot (250 us at 27 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 27, meaning clk cycles with all digits off between scan slots (anti-ghosting).
REQ-003 SHALL have port clk  input  1  sole clock, 27 MHz nominal.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  received UART byte (ASCII), valid only with rx_valid.
REQ-006 SHALL have port rx_valid  input  1  single-cycle strobe, rx_data valid.
REQ-007 SHALL have port seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port dp_n  output  1  decimal point of the driven digit, active-low.
REQ-009 SHALL have port dig_n  output  4  digit enables, active-low one-hot; bit 0 is the rightmost digit.
REQ-010 SHALL have port err  output  1  one-cycle pulse on an unsupported byte.

Function
REQ-011 SHALL hold a 4-entry digit buffer; each entry is nibble[3:0], used flag, dp flag.
REQ-012 SHALL decode '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66) to nibble values 0-15.
REQ-013 SHALL, on a valid hex byte, shift the buffer left one entry (entry 3 discarded) and load entry 0 with the nibble, used=1, dp=0.
REQ-014 SHALL, on '.' (0x2E), set dp of entry 0 with no shift; a second '.' is a no-op.
REQ-015 SHALL, on ESC (0x1B) or 'x'/'X' (0x78/0x58), clear all entries (used=0, dp=0).
REQ-016 SHALL ignore CR (0x0D) and LF (0x0A) with no buffer change and no err.
REQ-017 SHALL, on any other byte, leave the buffer unchanged and assert err for exactly the cycle after rx_valid.
REQ-018 SHALL apply buffer updates registered: rx_valid high in cycle N means the new buffer is visible in cycle N+1.
REQ-019 SHALL run a scan FSM with states ON and BLANK; ON lasts SCAN_CYC cycles, then BLANK lasts BLANK_CYC cycles, then the digit index increments (3 wraps to 0) and the FSM returns to ON.
REQ-020 SHALL, in ON, drive dig_n low only for the current index and drive seg_n/dp_n from that entry.
REQ-021 SHALL, in BLANK, drive dig_n=4'hF, seg_n=7'h7F and dp_n=1.
REQ-022 SHALL drive an entry with used=0 as seg_n=7'h7F, plus dp_n per its dp flag.
REQ-023 SHALL use segment patterns 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, active-low).
REQ-024 SHALL register all outputs, with no combinational path from rx_* to any output.
REQ-025 SHALL, when a buffer update hits the currently driven digit mid-slot, show the new pattern from cycle N+2 without restarting the slot timer.
REQ-026 SHALL keep scan timing completely independent of rx_valid activity.

Reset
REQ-027 SHALL, while reset is high at a clk edge, clear all buffer entries and load FSM=BLANK, index=0, timer=0.
REQ-028 SHALL drive dig_n=4'hF, seg_n=7'h7F, dp_n=1 and err=0 in the cycle after reset is sampled high.
REQ-029 SHALL discard a byte whose rx_valid coincides with reset.
REQ-030 SHALL, after reset deasserts, complete one BLANK of BLANK_CYC cycles and then enter ON with index 0.

Structure
REQ-031 SHALL take ASCII command constants, the 16-entry segment pattern table and the scan-state enum from shared package seg7_pkg.
REQ-032 SHALL place nibble-to-segment decoding in sub-module seg7_decode (nibble in, 7-bit active-low pattern out).
REQ-033 SHALL fit in 120-400 lines of RTL in total.

Verification
REQ-034 SHALL cover reset and idle: release reset, wait 30000 cycles -> dig_n cycles 1110,1101,1011,0111 with seg_n=7F throughout, and each ON slot lasts exactly 6750 cycles.
REQ-035 SHALL cover a hex sequence: send 0x41,0x35,0x36 ('A','5','6') -> digit2=08, digit1=12, digit0=02, digit3 blank.
REQ-036 SHALL cover overflow: send "12345" -> digits3..0 = 24,30,19,12 (the '1' is lost).
REQ-037 SHALL cover dp and clear: send '7','.' -> digit0 seg_n=78 with dp_n=0; then 'x' -> all blank, and no err on either command.
REQ-038 SHALL cover error and ignored bytes: send 0xAA -> err high for exactly one cycle, buffer unchanged; send 0x0D -> no err.
REQ-039 SHALL cover reset mid-operation: assert reset during ON of digit 2 with the buffer loaded -> outputs blank next cycle, and the scan restarts at index 0 after one BLANK.
